// File: rtl/mm_pkg.sv
// mm_pkg: shared types and helpers for the streaming matrix-multiply engine.
//   state_t      - sequencing states of the read/accumulate/write loop
//   acc_width()  - accumulator width that holds K_DIM full-range products
//   clip_*()     - saturation / truncation of an accumulator to DATA_W bits
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_C = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Widest accumulator the clip helpers operate on; callers zero-extend.
    localparam int unsigned CLIP_W = 64;

    // Each product is < 2^(2*data_w); k_dim of them sum below
    // 2^(2*data_w + clog2(k_dim)), so this width never overflows.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned k_dim);
        return 2 * data_w + $clog2(k_dim);
    endfunction

    function automatic logic [CLIP_W-1:0] max_value(input int unsigned data_w);
        if (data_w >= CLIP_W) begin
            return '1;
        end
        return (CLIP_W'(1) << data_w) - CLIP_W'(1);
    endfunction

    function automatic logic clip_needed(input logic [CLIP_W-1:0] acc,
                                         input int unsigned       data_w);
        return acc > max_value(data_w);
    endfunction

    function automatic logic [CLIP_W-1:0] clip_value(input logic [CLIP_W-1:0] acc,
                                                     input int unsigned       data_w,
                                                     input logic              saturate);
        if (saturate && clip_needed(acc, data_w)) begin
            return max_value(data_w);
        end
        return acc & max_value(data_w);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// mm_mac: multiply-accumulate datapath for one C element.
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - zero the accumulator (new element / new multiply)
//   load_a     - capture operand as the A element
//   accum      - add a_reg * operand into the accumulator
//   operand    - cache read data
//   result     - DATA_W view (clipped or truncated) of the accumulator
//                value *including* the product currently being added
//   clip       - that value exceeds 2^DATA_W-1 and SATURATE is set
module mm_mac
    import mm_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned K_DIM    = 64,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_a,
    input  logic              accum,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result,
    output logic              clip
);

    localparam int unsigned ACC_W = acc_width(DATA_W, K_DIM);

    logic [DATA_W-1:0]   a_reg;
    logic [ACC_W-1:0]    acc;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_sum;

    always_comb begin
        prod     = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, operand};
        prod_ext = '0;
        prod_ext[2*DATA_W-1:0] = prod;
        acc_sum  = acc + prod_ext;
    end

    // Result is taken from the running sum so the top can register the
    // final element value on the same edge as the last accumulation.
    always_comb begin
        result = DATA_W'(clip_value(CLIP_W'(acc_sum), DATA_W, SATURATE));
        clip   = SATURATE && clip_needed(CLIP_W'(acc_sum), DATA_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            acc   <= '0;
        end else begin
            if (load_a) begin
                a_reg <= operand;
            end
            if (clear) begin
                acc <= '0;
            end else if (accum) begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: streaming C = A x B through one processor-side cache
// port, one element per request (row-major, one element per address).
//   CLK, RST              - clock, asynchronous active-high reset
//   start                 - begin a multiply (accepted only when idle)
//   busy / done           - running flag / one-cycle completion pulse
//   sat_seen              - sticky: some C element was clipped
//   Pr_Rd, Pr_Wr, Address - cache request, held until its done arrives
//   write_data            - C element for Pr_Wr
//   read_data, read_done  - read completion and its data
//   write_done            - write completion
module matrix_mult_engine
    import mm_pkg::*;
#(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          N_ROWS   = 64,
    parameter int unsigned          K_DIM    = 64,
    parameter int unsigned          P_COLS   = 64,
    parameter int unsigned          ADDR_W   = 37,
    parameter logic [ADDR_W-1:0]    A_BASE   = ADDR_W'(0),
    parameter logic [ADDR_W-1:0]    B_BASE   = ADDR_W'(4096),
    parameter logic [ADDR_W-1:0]    C_BASE   = ADDR_W'(8192),
    parameter bit                   SATURATE = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sat_seen,
    output logic              Pr_Rd,
    output logic              Pr_Wr,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_done,
    input  logic              write_done
);

    localparam int unsigned I_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int unsigned J_W = (P_COLS > 1) ? $clog2(P_COLS) : 1;
    localparam int unsigned K_W = (K_DIM  > 1) ? $clog2(K_DIM)  : 1;

    localparam logic [I_W-1:0] I_LAST = I_W'(N_ROWS - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(P_COLS - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K_DIM - 1);

    state_t state, next_state;

    logic [I_W-1:0] i, i_n;
    logic [J_W-1:0] j, j_n;
    logic [K_W-1:0] k, k_n;

    logic              rd_ack, wr_ack, k_last, last_elem;
    logic              mac_clear, mac_load, mac_accum, mac_clip;
    logic [DATA_W-1:0] mac_result;

    logic              rd_d, wr_d, busy_d, done_d, sat_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wd_d;

    // Only the completion matching the outstanding request type counts.
    assign rd_ack    = ((state == ST_RD_A) || (state == ST_RD_B)) && read_done;
    assign wr_ack    = (state == ST_WR_C) && write_done;
    assign k_last    = (k == K_LAST);
    assign last_elem = (i == I_LAST) && (j == J_LAST);

    assign mac_clear = ((state == ST_IDLE) && start) || wr_ack;
    assign mac_load  = (state == ST_RD_A) && read_done;
    assign mac_accum = (state == ST_RD_B) && read_done;

    mm_mac #(
        .DATA_W   (DATA_W),
        .K_DIM    (K_DIM),
        .SATURATE (SATURATE)
    ) u_mac (
        .clk     (CLK),
        .rst     (RST),
        .clear   (mac_clear),
        .load_a  (mac_load),
        .accum   (mac_accum),
        .operand (read_data),
        .result  (mac_result),
        .clip    (mac_clip)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)  next_state = ST_RD_A;
            ST_RD_A: if (rd_ack) next_state = ST_RD_B;
            ST_RD_B: if (rd_ack) next_state = k_last ? ST_WR_C : ST_RD_A;
            ST_WR_C: if (wr_ack) next_state = last_elem ? ST_FIN : ST_RD_A;
            ST_FIN:              next_state = ST_IDLE;
            default:             next_state = ST_IDLE;
        endcase
    end

    // Index update: k innermost, then j, then i
    always_comb begin
        i_n = i;
        j_n = j;
        k_n = k;
        if ((state == ST_IDLE) && start) begin
            i_n = '0;
            j_n = '0;
            k_n = '0;
        end else if ((state == ST_RD_B) && rd_ack) begin
            k_n = k_last ? '0 : k + K_W'(1);
        end else if (wr_ack) begin
            if (j == J_LAST) begin
                j_n = '0;
                i_n = (i == I_LAST) ? '0 : i + I_W'(1);
            end else begin
                j_n = j + J_W'(1);
            end
        end
    end

    // Output logic: request outputs are computed from the next state and
    // next indices so the registered request is valid in the cycle that
    // follows the completion (back-to-back issue). done is registered off
    // the FIN state itself, so it lands in the cycle after FIN.
    always_comb begin
        rd_d   = (next_state == ST_RD_A) || (next_state == ST_RD_B);
        wr_d   = (next_state == ST_WR_C);
        busy_d = (next_state != ST_IDLE);
        done_d = (state == ST_FIN);
        case (next_state)
            ST_RD_A: addr_d = A_BASE + ADDR_W'(i_n) * ADDR_W'(K_DIM)  + ADDR_W'(k_n);
            ST_RD_B: addr_d = B_BASE + ADDR_W'(k_n) * ADDR_W'(P_COLS) + ADDR_W'(j_n);
            ST_WR_C: addr_d = C_BASE + ADDR_W'(i_n) * ADDR_W'(P_COLS) + ADDR_W'(j_n);
            default: addr_d = '0;
        endcase
        wd_d  = write_data;
        sat_d = sat_seen;
        if ((state == ST_IDLE) && start) begin
            sat_d = 1'b0;
        end else if ((state == ST_RD_B) && rd_ack && k_last) begin
            wd_d = mac_result;
            if (mac_clip) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            Pr_Rd      <= 1'b0;
            Pr_Wr      <= 1'b0;
            Address    <= '0;
            write_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sat_seen   <= 1'b0;
        end else begin
            i          <= i_n;
            j          <= j_n;
            k          <= k_n;
            Pr_Rd      <= rd_d;
            Pr_Wr      <= wr_d;
            Address    <= addr_d;
            write_data <= wd_d;
            busy       <= busy_d;
            done       <= done_d;
            sat_seen   <= sat_d;
        end
    end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Bench for matrix_mult_engine: several parameterisations share one cache
// responder through a select mux; every request trace and C value is
// compared against a nested-loop reference model.
module tb_matrix_mult_engine;

    localparam int unsigned AW   = 37;
    localparam int unsigned NDUT = 5;
    localparam logic [AW-1:0] C_TOP = 37'h1F_FFFF_FFFE;

    logic            CLK, RST, start;
    logic [2:0]      sel;
    logic [7:0]      read_data;
    logic            read_done, write_done;

    logic [NDUT-1:0] busy_v, done_v, sat_v, rd_v, wr_v;
    logic [AW-1:0]   addr_v [NDUT];
    logic [7:0]      wd_v   [NDUT];

    logic            busy, done, sat_seen, pr_rd, pr_wr;
    logic [AW-1:0]   address;
    logic [7:0]      write_data;

    assign busy       = busy_v[sel];
    assign done       = done_v[sel];
    assign sat_seen   = sat_v[sel];
    assign pr_rd      = rd_v[sel];
    assign pr_wr      = wr_v[sel];
    assign address    = addr_v[sel];
    assign write_data = wd_v[sel];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]      mem [logic [AW-1:0]];
    logic [63:0]     act_q [$];
    logic [63:0]     exp_q [$];
    int unsigned     lat_mode, cur_lat, wait_cnt;
    bit              spur_en;
    int unsigned     a_m [64];
    int unsigned     b_m [64];

    matrix_mult_engine #(.N_ROWS(2), .K_DIM(2), .P_COLS(2), .SATURATE(1'b1)) u0 (
        .CLK(CLK), .RST(RST), .start(start && sel == 3'd0),
        .busy(busy_v[0]), .done(done_v[0]), .sat_seen(sat_v[0]),
        .Pr_Rd(rd_v[0]), .Pr_Wr(wr_v[0]), .Address(addr_v[0]), .write_data(wd_v[0]),
        .read_data(read_data), .read_done(read_done && sel == 3'd0),
        .write_done(write_done && sel == 3'd0));

    matrix_mult_engine #(.N_ROWS(4), .K_DIM(4), .P_COLS(4), .SATURATE(1'b1)) u1 (
        .CLK(CLK), .RST(RST), .start(start && sel == 3'd1),
        .busy(busy_v[1]), .done(done_v[1]), .sat_seen(sat_v[1]),
        .Pr_Rd(rd_v[1]), .Pr_Wr(wr_v[1]), .Address(addr_v[1]), .write_data(wd_v[1]),
        .read_data(read_data), .read_done(read_done && sel == 3'd1),
        .write_done(write_done && sel == 3'd1));

    matrix_mult_engine #(.N_ROWS(4), .K_DIM(4), .P_COLS(4), .SATURATE(1'b0)) u2 (
        .CLK(CLK), .RST(RST), .start(start && sel == 3'd2),
        .busy(busy_v[2]), .done(done_v[2]), .sat_seen(sat_v[2]),
        .Pr_Rd(rd_v[2]), .Pr_Wr(wr_v[2]), .Address(addr_v[2]), .write_data(wd_v[2]),
        .read_data(read_data), .read_done(read_done && sel == 3'd2),
        .write_done(write_done && sel == 3'd2));

    matrix_mult_engine #(.N_ROWS(3), .K_DIM(5), .P_COLS(2), .SATURATE(1'b1)) u3 (
        .CLK(CLK), .RST(RST), .start(start && sel == 3'd3),
        .busy(busy_v[3]), .done(done_v[3]), .sat_seen(sat_v[3]),
        .Pr_Rd(rd_v[3]), .Pr_Wr(wr_v[3]), .Address(addr_v[3]), .write_data(wd_v[3]),
        .read_data(read_data), .read_done(read_done && sel == 3'd3),
        .write_done(write_done && sel == 3'd3));

    matrix_mult_engine #(.N_ROWS(1), .K_DIM(8), .P_COLS(3), .A_BASE(37'd100),
                         .B_BASE(37'd300), .C_BASE(C_TOP), .SATURATE(1'b1)) u4 (
        .CLK(CLK), .RST(RST), .start(start && sel == 3'd4),
        .busy(busy_v[4]), .done(done_v[4]), .sat_seen(sat_v[4]),
        .Pr_Rd(rd_v[4]), .Pr_Wr(wr_v[4]), .Address(addr_v[4]), .write_data(wd_v[4]),
        .read_data(read_data), .read_done(read_done && sel == 3'd4),
        .write_done(write_done && sel == 3'd4));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Cache responder: answers each request after cur_lat cycles, checks the
    // request is held stable meanwhile, and optionally injects the wrong
    // completion type while waiting and alongside the real one.
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_wd;
    logic          hold_rd, hold_wr;

    initial begin
        read_done  = 1'b0;
        write_done = 1'b0;
        read_data  = '0;
        wait_cnt   = 0;
        forever begin
            @(negedge CLK);
            read_done  = 1'b0;
            write_done = 1'b0;
            if (RST) begin
                wait_cnt = 0;
            end else if (pr_rd || pr_wr) begin
                check("excl", 64'(pr_rd & pr_wr), 64'd0);
                wait_cnt++;
                if (wait_cnt == 1) begin
                    hold_addr = address;
                    hold_wd   = write_data;
                    hold_rd   = pr_rd;
                    hold_wr   = pr_wr;
                end else begin
                    check("stable", 64'({pr_rd, pr_wr, write_data, address}),
                          64'({hold_rd, hold_wr, hold_wd, hold_addr}));
                end
                if (wait_cnt >= cur_lat) begin
                    wait_cnt = 0;
                    if (pr_rd) begin
                        read_data = mem.exists(address) ? mem[address] : 8'h00;
                        read_done = 1'b1;
                        act_q.push_back({18'd0, 1'b0, address, 8'h00});
                        if (spur_en) write_done = 1'b1;
                    end else begin
                        mem[address] = write_data;
                        write_done   = 1'b1;
                        act_q.push_back({18'd0, 1'b1, address, write_data});
                        if (spur_en) begin
                            read_data = 8'($urandom);
                            read_done = 1'b1;
                        end
                    end
                    cur_lat = (lat_mode == 0) ? $urandom_range(1, 5) : lat_mode;
                end else if (spur_en && wait_cnt == 1) begin
                    if (pr_rd) write_done = 1'b1;
                    else       read_done  = 1'b1;
                end
            end
        end
    end

    // fill: 0 random, 1 all 255, 2 A=1..4 / B=5..8
    task automatic load_and_model(input int unsigned n, input int unsigned kd,
                                  input int unsigned p, input logic [AW-1:0] ab,
                                  input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                                  input bit sat, input int unsigned fill,
                                  output bit exp_sat);
        longint unsigned acc;
        logic [7:0]      val;
        mem.delete();
        exp_q.delete();
        exp_sat = 1'b0;
        for (int unsigned x = 0; x < n * kd; x++) begin
            a_m[x] = (fill == 1) ? 255 : (fill == 2) ? x + 1 : $urandom_range(0, 15);
            mem[ab + AW'(x)] = 8'(a_m[x]);
        end
        for (int unsigned x = 0; x < kd * p; x++) begin
            b_m[x] = (fill == 1) ? 255 : (fill == 2) ? x + 5 : $urandom_range(0, 15);
            mem[bb + AW'(x)] = 8'(b_m[x]);
        end
        for (int unsigned r = 0; r < n; r++) begin
            for (int unsigned c = 0; c < p; c++) begin
                acc = 0;
                for (int unsigned m = 0; m < kd; m++) begin
                    exp_q.push_back({18'd0, 1'b0, ab + AW'(r * kd + m), 8'h00});
                    exp_q.push_back({18'd0, 1'b0, bb + AW'(m * p + c), 8'h00});
                    acc += longint'(a_m[r * kd + m]) * longint'(b_m[m * p + c]);
                end
                if (sat && acc > 255) begin
                    val     = 8'd255;
                    exp_sat = 1'b1;
                end else begin
                    val = 8'(acc % 256);
                end
                exp_q.push_back({18'd0, 1'b1, cb + AW'(r * p + c), val});
            end
        end
    endtask

    task automatic run_test(input logic [2:0] s, input int unsigned n, input int unsigned kd,
                            input int unsigned p, input logic [AW-1:0] ab,
                            input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                            input bit sat, input int unsigned lat, input int unsigned fill,
                            input bit spur, input bit chk_cyc);
        bit exp_sat;
        bit seen;
        int unsigned cnt;
        int unsigned nmin;
        sel      = s;
        lat_mode = lat;
        cur_lat  = (lat == 0) ? $urandom_range(1, 5) : lat;
        spur_en  = spur;
        load_and_model(n, kd, p, ab, bb, cb, sat, fill, exp_sat);
        act_q.delete();
        @(negedge CLK);
        start = 1'b1;
        cnt   = 0;
        seen  = 1'b0;
        while (!seen && cnt < 5000) begin
            @(negedge CLK);
            cnt++;
            start = spur && (cnt == 10 || cnt == 30);
            if (cnt == 1) begin
                check("busy_rise", 64'(busy), 64'd1);
                check("first_req", 64'({pr_rd, pr_wr, address}), 64'({2'b10, ab}));
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        if (chk_cyc) check("cycles", 64'(cnt), 64'(n * p * (2 * kd + 1) * lat + 2));
        check("busy_at_done", 64'(busy), 64'd0);
        check("sat_seen", 64'(sat_seen), 64'(exp_sat));
        @(negedge CLK);
        check("done_pulse", 64'(done), 64'd0);
        check("trace_len", 64'(act_q.size()), 64'(exp_q.size()));
        nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int unsigned x = 0; x < nmin; x++) begin
            check("trace", act_q[x], exp_q[x]);
        end
        spur_en = 1'b0;
    endtask

    task automatic reset_mid_rdb();
        bit found;
        sel      = 3'd3;
        lat_mode = 2;
        cur_lat  = 2;
        spur_en  = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            if (pr_rd && address >= 37'd4096 && address < 37'd8192) found = 1'b1;
        end
        check("rdb_reached", 64'(found), 64'd1);
        #1 RST = 1'b1;
        #1;
        check("rst_mid", 64'({pr_rd, pr_wr, busy, done, sat_seen, write_data, address}), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("rst_hold", 64'({pr_rd, pr_wr, busy, done}), 64'd0);
        RST = 1'b0;
    endtask

    initial begin
        RST      = 1'b1;
        start    = 1'b0;
        sel      = 3'd0;
        lat_mode = 1;
        cur_lat  = 1;
        spur_en  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", 64'({pr_rd, pr_wr, busy, done, sat_seen, write_data, address}), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_after_reset", 64'({pr_rd, pr_wr, busy, done}), 64'd0);

        run_test(3'd0, 2, 2, 2, 37'd0, 37'd4096, 37'd8192, 1'b1, 1, 2, 1'b0, 1'b1);
        run_test(3'd1, 4, 4, 4, 37'd0, 37'd4096, 37'd8192, 1'b1, 2, 1, 1'b0, 1'b1);
        run_test(3'd2, 4, 4, 4, 37'd0, 37'd4096, 37'd8192, 1'b0, 2, 1, 1'b0, 1'b1);
        repeat (2) run_test(3'd3, 3, 5, 2, 37'd0, 37'd4096, 37'd8192, 1'b1, 0, 0, 1'b0, 1'b0);
        run_test(3'd0, 2, 2, 2, 37'd0, 37'd4096, 37'd8192, 1'b1, 3, 0, 1'b1, 1'b1);
        reset_mid_rdb();
        run_test(3'd3, 3, 5, 2, 37'd0, 37'd4096, 37'd8192, 1'b1, 0, 0, 1'b0, 1'b0);
        run_test(3'd4, 1, 8, 3, 37'd100, 37'd300, C_TOP, 1'b1, 1, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_mult_engine.md
# matrix_mult_engine

Parametrised streaming matrix-multiply engine that computes C = A × B for unsigned operands held in cache memory, through one processor-side cache port. It replaces whole-matrix register buffering with an element-at-a-time read/accumulate/write FSM, so matrix dimensions, data width and base addresses scale without array storage. It sits in the processor slot in front of a coherent cache controller and drives the Pr_Rd/Pr_Wr request handshake.

## Interface
- DATA_W, 8, element width in bits
- N_ROWS, 64, rows of A and C
- K_DIM, 64, columns of A, rows of B
- P_COLS, 64, columns of B and C
- ADDR_W, 37, cache address width
- A_BASE / B_BASE / C_BASE, 0 / 4096 / 8192, element-0 address of each matrix; row-major, one element per address
- SATURATE, 1, 1: clip result to 2^DATA_W-1; 0: keep low DATA_W bits
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a multiply when idle
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the last C element write completes
- sat_seen  out  1  sticky; set when any element clipped, cleared on accepted start
- Pr_Rd  out  1  read request to cache
- Pr_Wr  out  1  write request to cache
- Address  out  ADDR_W  request address
- write_data  out  DATA_W  data for Pr_Wr
- read_data  in  DATA_W  cache read data, valid in the read_done cycle
- read_done  in  1  read completion pulse
- write_done  in  1  write completion pulse

## Operation
- States: IDLE, RD_A, RD_B, WR_C, FIN.
- IDLE: start=1 → clear i,j,k, accumulator, sat_seen; go RD_A. start while not IDLE ignored.
- RD_A: Pr_Rd=1, Address=A_BASE+i·K_DIM+k. On read_done: latch a_reg=read_data; go RD_B.
- RD_B: Pr_Rd=1, Address=B_BASE+k·P_COLS+j. On read_done: acc += a_reg·read_data; if k==K_DIM-1 go WR_C (k←0) else k++, go RD_A.
- WR_C: Pr_Wr=1, Address=C_BASE+i·P_COLS+j, write_data = clip or truncation of acc per SATURATE. On write_done: acc←0; j++ (wrap to 0 with i++); after (N_ROWS-1,P_COLS-1) go FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Accumulator width ACC_W = 2·DATA_W + clog2(K_DIM); never overflows. Clip when acc > 2^DATA_W-1; sets sat_seen (SATURATE=1 only).
- Address arithmetic done in ADDR_W bits, wraps modulo 2^ADDR_W.

## Timing
- All outputs registered. Reset values: Pr_Rd=0, Pr_Wr=0, Address=0, write_data=0, busy=0, done=0, sat_seen=0; state IDLE.
- First request (RD_A, i=j=k=0) appears the cycle after start is sampled.
- Request and Address held stable until the matching done is sampled; next request appears in the following cycle (back-to-back, no idle cycle). Pr_Rd and Pr_Wr never high together.
- read_done in WR_C, write_done in RD_A/RD_B, any done in IDLE/FIN: ignored. Both dones in the same cycle: only the one matching the current request acts.
- With a cache answering each request after L cycles, total start→done = N_ROWS·P_COLS·(2·K_DIM+1)·L + 2 cycles.
- RST mid-operation: immediate abort, requests dropped, no done pulse, partial C left in cache.

## Structure
- Package mm_pkg: state enum, ACC_W derivation function, clip function.
- Sub-module mm_mac: a_reg × read_data accumulate, clear, saturate/truncate output and clip flag; FSM plus index counters and address generation stay in the top.

## Test plan
- 2×2×2, SATURATE=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]], L=1 → C writes 19,22,43,50 at C_BASE..+3, done after 2·2·5+2=22 cycles, sat_seen=0.
- 4×4×4 all elements 255, SATURATE=1 → every C write 255, sat_seen=1; SATURATE=0 → every C write 0x04 (260100 mod 256).
- Random cache latency 1–5 cycles, 3×5×2 random data → C matches golden model; Address/Pr_* stable while waiting.
- Spurious write_done during RD_B and read_done during WR_C, plus start pulse while busy → no state advance, no restart.
- RST asserted mid RD_B → all outputs zero same cycle; new start afterwards yields correct full result.
- Non-square 1×8×3, non-zero bases → addresses A_BASE+0..7, B_BASE+k·3+j, C_BASE+0..2 in exact order.
